// File: rtl/reg_status_mp.sv
// Register status table: per-register in-flight writer counter plus the ROB
// entry of the youngest writer, read combinationally by two source ports.
package expipe_pkg;
  parameter int ROB_IDX_LEN = 6;
endpackage

// Handshakes: an issue is accepted when issuel_valid_i && issuel_ready_o in
// the same cycle; a commit is accepted whenever comm_valid_i (comm_ready_o is 1).
module reg_status_mp #(
  parameter int REG_NUM     = 32,
  parameter int REG_IDX_LEN = 5,
  parameter int ROB_IDX_LEN = expipe_pkg::ROB_IDX_LEN,
  parameter int BUSY_CNT_W  = 3,
  parameter bit SKIP_X0     = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   issuel_valid_i,
  output logic                   issuel_ready_o,
  input  logic [REG_IDX_LEN-1:0] issue_rd_idx_i,
  input  logic [ROB_IDX_LEN-1:0] issue_rob_idx_i,
  input  logic [REG_IDX_LEN-1:0] issue_rs1_idx_i,
  input  logic [REG_IDX_LEN-1:0] issue_rs2_idx_i,
  output logic                   issue_rs1_busy_o,
  output logic                   issue_rs2_busy_o,
  output logic [ROB_IDX_LEN-1:0] issue_rs1_rob_idx_o,
  output logic [ROB_IDX_LEN-1:0] issue_rs2_rob_idx_o,
  input  logic                   comm_valid_i,
  output logic                   comm_ready_o,
  input  logic [REG_IDX_LEN-1:0] comm_rd_idx_i,
  output logic                   comm_err_o
);

  localparam logic [BUSY_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [BUSY_CNT_W-1:0] CNT_ONE = BUSY_CNT_W'(1);

  logic [REG_NUM-1:0][BUSY_CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_NUM-1:0][ROB_IDX_LEN-1:0] rob_q, rob_d;
  logic                                comm_err_q, comm_err_d;

  logic issue_ok, comm_ok, same_rd, rd_full, issue_acc, comm_zero;
  logic inc, com;

  // Register 0 (when skipped) and indices past REG_NUM are untracked.
  function automatic logic idx_ok(input logic [REG_IDX_LEN-1:0] idx);
    idx_ok = (32'(idx) < REG_NUM) && !(SKIP_X0 && (idx == '0));
  endfunction

  always_comb begin
    issue_ok       = idx_ok(issue_rd_idx_i);
    comm_ok        = comm_valid_i && idx_ok(comm_rd_idx_i);
    same_rd        = comm_ok && issue_ok && (comm_rd_idx_i == issue_rd_idx_i);
    rd_full        = issue_ok && (cnt_q[issue_rd_idx_i] == CNT_MAX);
    // A commit to the full register frees a slot in the same cycle.
    issuel_ready_o = !(rd_full && !same_rd);
    issue_acc      = issuel_valid_i && issuel_ready_o && issue_ok;
    comm_zero      = comm_ok && (cnt_q[comm_rd_idx_i] == '0);
  end

  always_comb begin
    cnt_d      = cnt_q;
    rob_d      = rob_q;
    comm_err_d = comm_zero;
    inc        = 1'b0;
    com        = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      inc = issue_acc && (issue_rd_idx_i == REG_IDX_LEN'(i));
      com = comm_ok && (comm_rd_idx_i == REG_IDX_LEN'(i));
      if (inc) begin
        rob_d[i] = issue_rob_idx_i;
        if (!com) cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (com && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    if (flush_i) begin
      cnt_d      = '0;
      rob_d      = '0;
      comm_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      rob_q      <= '0;
      comm_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      rob_q      <= rob_d;
      comm_err_q <= comm_err_d;
    end
  end

  always_comb begin
    issue_rs1_busy_o    = 1'b0;
    issue_rs1_rob_idx_o = '0;
    issue_rs2_busy_o    = 1'b0;
    issue_rs2_rob_idx_o = '0;
    if (idx_ok(issue_rs1_idx_i)) begin
      issue_rs1_busy_o    = |cnt_q[issue_rs1_idx_i];
      issue_rs1_rob_idx_o = rob_q[issue_rs1_idx_i];
    end
    if (idx_ok(issue_rs2_idx_i)) begin
      issue_rs2_busy_o    = |cnt_q[issue_rs2_idx_i];
      issue_rs2_rob_idx_o = rob_q[issue_rs2_idx_i];
    end
  end

  assign comm_ready_o = 1'b1;
  assign comm_err_o   = comm_err_q;

endmodule

// File: tb/tb_reg_status_mp.sv
// Directed bench for reg_status_mp: hand-computed expectations checked with
// immediate assertions after each step.
module tb_reg_status_mp;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       issue_valid;
  logic       issue_ready;
  logic [4:0] issue_rd;
  logic [5:0] issue_rob;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic       rs1_busy;
  logic       rs2_busy;
  logic [5:0] rs1_rob;
  logic [5:0] rs2_rob;
  logic       comm_valid;
  logic       comm_ready;
  logic [4:0] comm_rd;
  logic       comm_err;

  int asserts_n = 0;
  int fail_n    = 0;

  reg_status_mp #(
    .REG_NUM(32), .REG_IDX_LEN(5), .ROB_IDX_LEN(6), .BUSY_CNT_W(3), .SKIP_X0(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issuel_valid_i(issue_valid), .issuel_ready_o(issue_ready),
    .issue_rd_idx_i(issue_rd), .issue_rob_idx_i(issue_rob),
    .issue_rs1_idx_i(rs1_idx), .issue_rs2_idx_i(rs2_idx),
    .issue_rs1_busy_o(rs1_busy), .issue_rs2_busy_o(rs2_busy),
    .issue_rs1_rob_idx_o(rs1_rob), .issue_rs2_rob_idx_o(rs2_rob),
    .comm_valid_i(comm_valid), .comm_ready_o(comm_ready),
    .comm_rd_idx_i(comm_rd), .comm_err_o(comm_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts_n++;
    assert (obs === exp) else begin
      fail_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    comm_valid  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic drive_issue(input logic [4:0] rd, input logic [5:0] rob);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_rob   = rob;
  endtask

  task automatic drive_commit(input logic [4:0] rd);
    comm_valid = 1'b1;
    comm_rd    = rd;
  endtask

  task automatic read(input logic [4:0] a, input logic [4:0] b);
    rs1_idx = a;
    rs2_idx = b;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    issue_rd = '0; issue_rob = '0; comm_rd = '0; rs1_idx = '0; rs2_idx = '0;
    #3;
    chk("rst_busy", {31'd0, rs1_busy}, 32'd0);
    chk("rst_err", {31'd0, comm_err}, 32'd0);
    #9 rst = 1'b0;
    tick();

    // Post-reset outputs
    read(5'd5, 5'd31);
    chk("init_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    chk("init_rs1_rob", {26'd0, rs1_rob}, 32'd0);
    chk("init_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    chk("init_ready", {31'd0, issue_ready}, 32'd1);
    chk("init_comm_ready", {31'd0, comm_ready}, 32'd1);

    // Basic issue then commit on rd=5; same-cycle read shows no bypass
    drive_issue(5'd5, 6'd3);
    read(5'd5, 5'd5);
    chk("nobypass_busy", {31'd0, rs2_busy}, 32'd0);
    tick(); idle();
    read(5'd5, 5'd0);
    chk("iss5_busy", {31'd0, rs1_busy}, 32'd1);
    chk("iss5_rob", {26'd0, rs1_rob}, 32'd3);
    drive_commit(5'd5);
    tick(); idle();
    read(5'd5, 5'd0);
    chk("com5_busy", {31'd0, rs1_busy}, 32'd0);
    chk("com5_rob", {26'd0, rs1_rob}, 32'd3);
    chk("com5_err", {31'd0, comm_err}, 32'd0);

    // Commit to an idle register pulses comm_err_o for one cycle
    drive_commit(5'd9);
    tick(); idle();
    read(5'd9, 5'd0);
    chk("err9_pulse", {31'd0, comm_err}, 32'd1);
    chk("err9_busy", {31'd0, rs1_busy}, 32'd0);
    tick();
    chk("err9_clear", {31'd0, comm_err}, 32'd0);

    // Fill rd=7 to the counter maximum
    for (int k = 0; k < 7; k++) begin
      drive_issue(5'd7, 6'(10 + k));
      tick();
    end
    idle();
    drive_issue(5'd7, 6'd20);
    #1;
    chk("full7_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    read(5'd7, 5'd0);
    chk("full7_rob_kept", {26'd0, rs1_rob}, 32'd16);
    drive_issue(5'd7, 6'd21);
    drive_commit(5'd7);
    #1;
    chk("full7_ready_comm", {31'd0, issue_ready}, 32'd1);
    tick(); idle();
    read(5'd7, 5'd0);
    chk("full7_rob_new", {26'd0, rs1_rob}, 32'd21);
    drive_issue(5'd7, 6'd22);
    #1;
    chk("full7_still_max", {31'd0, issue_ready}, 32'd0);
    idle();

    // Independent issue rd=4 and commit rd=7
    drive_issue(5'd4, 6'd5);
    drive_commit(5'd7);
    tick(); idle();
    read(5'd4, 5'd7);
    chk("indep4_busy", {31'd0, rs1_busy}, 32'd1);
    chk("indep4_rob", {26'd0, rs1_rob}, 32'd5);
    chk("indep7_busy", {31'd0, rs2_busy}, 32'd1);
    drive_issue(5'd7, 6'd23);
    #1;
    chk("indep7_ready", {31'd0, issue_ready}, 32'd1);
    idle();

    // Register 0 is never tracked
    drive_issue(5'd0, 6'd4);
    #1;
    chk("x0_ready", {31'd0, issue_ready}, 32'd1);
    tick(); idle();
    read(5'd0, 5'd0);
    chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
    chk("x0_rob", {26'd0, rs1_rob}, 32'd0);
    drive_commit(5'd0);
    tick(); idle();
    chk("x0_no_err", {31'd0, comm_err}, 32'd0);

    // Flush overrides a same-cycle issue and a zero-counter commit
    drive_issue(5'd2, 6'd1);
    tick();
    drive_issue(5'd3, 6'd2);
    tick(); idle();
    read(5'd2, 5'd3);
    chk("pre_flush2", {31'd0, rs1_busy}, 32'd1);
    chk("pre_flush3", {26'd0, rs2_rob}, 32'd2);
    flush = 1'b1;
    drive_issue(5'd2, 6'd7);
    drive_commit(5'd9);
    tick(); idle();
    read(5'd2, 5'd3);
    chk("flush2_busy", {31'd0, rs1_busy}, 32'd0);
    chk("flush2_rob", {26'd0, rs1_rob}, 32'd0);
    chk("flush3_busy", {31'd0, rs2_busy}, 32'd0);
    chk("flush_err", {31'd0, comm_err}, 32'd0);
    read(5'd7, 5'd4);
    chk("flush7_busy", {31'd0, rs1_busy}, 32'd0);
    chk("flush4_rob", {26'd0, rs2_rob}, 32'd0);

    // Asynchronous reset between edges
    drive_issue(5'd6, 6'd11);
    drive_commit(5'd10);
    tick();
    read(5'd6, 5'd0);
    chk("pre_rst_busy", {31'd0, rs1_busy}, 32'd1);
    chk("pre_rst_err", {31'd0, comm_err}, 32'd1);
    issue_rob = 6'd12;
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, rs1_busy}, 32'd0);
    chk("async_rst_rob", {26'd0, rs1_rob}, 32'd0);
    chk("async_rst_err", {31'd0, comm_err}, 32'd0);
    tick(); idle();
    #2 rst = 1'b0;
    #1;
    chk("rel_ready", {31'd0, issue_ready}, 32'd1);
    chk("rel_busy", {31'd0, rs1_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts_n, fail_n);
    $finish;
  end

endmodule

// File: doc/reg_status_mp.md
REG_STATUS_MP -- requirements
Module: reg_status_mp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter REG_NUM, default 32: number of tracked architectural registers.
REQ-003 Parameter REG_IDX_LEN, default 5: register index width, equal to clog2(REG_NUM).
REQ-004 Parameter ROB_IDX_LEN, default expipe_pkg ROB_IDX_LEN: ROB index width.
REQ-005 Parameter BUSY_CNT_W, default 3: width of each per-register in-flight writer counter.
REQ-006 Parameter SKIP_X0, default 1: when 1, register 0 is never tracked.
REQ-007 clk_i  in  1  clock; all state updates occur on its rising edge.
REQ-008 rst_i  in  1  asynchronous active-high reset.
REQ-009 flush_i  in  1  synchronous clear of all status.
REQ-010 issuel_valid_i / issuel_ready_o  in/out  1/1  issue handshake.
REQ-011 issue_rd_idx_i  in  REG_IDX_LEN  destination register of the issuing instruction.
REQ-012 issue_rob_idx_i  in  ROB_IDX_LEN  ROB tail entry allocated to the issuing instruction.
REQ-013 issue_rs1_idx_i, issue_rs2_idx_i  in  REG_IDX_LEN  source register indices.
REQ-014 issue_rs1_busy_o, issue_rs2_busy_o  out  1  source has at least one in-flight writer.
REQ-015 issue_rs1_rob_idx_o, issue_rs2_rob_idx_o  out  ROB_IDX_LEN  ROB entry of the youngest writer.
REQ-016 comm_valid_i / comm_ready_o  in/out  1/1  commit handshake; comm_ready_o is constant 1.
REQ-017 comm_rd_idx_i  in  REG_IDX_LEN  destination register of the committing instruction.
REQ-018 comm_err_o  out  1  one-cycle pulse reporting a commit to a register whose counter is zero.

Function
REQ-019 Each register SHALL hold an unsigned BUSY_CNT_W-bit counter and a ROB_IDX_LEN-bit rob_idx.
REQ-020 An issue SHALL be accepted when issuel_valid_i and issuel_ready_o are both 1 in the same cycle.
REQ-021 issuel_ready_o SHALL be 0 only when the issue_rd_idx_i counter is at its maximum (2^BUSY_CNT_W-1) and no commit to the same register is occurring in that cycle; otherwise 1.
REQ-022 An accepted issue SHALL increment the rd counter by 1 and load rd rob_idx with issue_rob_idx_i on the next edge.
REQ-023 A commit (comm_valid_i=1) to a register with a non-zero counter SHALL decrement that counter by 1; rob_idx is unchanged.
REQ-024 A commit to a register with a zero counter SHALL leave state unchanged and SHALL assert comm_err_o for exactly the following cycle.
REQ-025 An accepted issue and a valid commit to the same register in the same cycle SHALL leave the counter unchanged and load rob_idx from issue_rob_idx_i.
REQ-026 Issue and commit to different registers in the same cycle SHALL both take effect independently.
REQ-027 When SKIP_X0=1, issue and commit to register 0 SHALL not modify state, issuel_ready_o SHALL be 1, comm_err_o SHALL not assert, and reads of register 0 SHALL return busy=0, rob_idx=0.
REQ-028 Counters SHALL never wrap: no increment at maximum, no decrement at zero.
REQ-029 issue_rsX_busy_o SHALL be the OR-reduction of the rsX counter; issue_rsX_rob_idx_o SHALL be rsX rob_idx; both SHALL be combinational from current state (zero cycles), with no bypass of same-cycle issue or commit.
REQ-030 flush_i=1 SHALL clear all counters and rob_idx fields and the comm_err_o register on the next edge, overriding any same-cycle issue or commit.
REQ-031 Out-of-range indices (>= REG_NUM) SHALL not modify state and SHALL read as busy=0, rob_idx=0.

Reset
REQ-032 While rst_i=1, all counters, rob_idx fields and comm_err_o SHALL be 0 immediately, independent of clk_i.
REQ-033 After reset release, issue_rsX_busy_o SHALL be 0, issue_rsX_rob_idx_o 0, issuel_ready_o 1, comm_ready_o 1.
REQ-034 Reset asserted mid-operation SHALL discard any in-progress issue or commit update.

Verification
REQ-035 Issue rd=5 rob=3, next cycle read rs1=5 -> busy=1, rob_idx=3; commit rd=5 -> rs1 busy=0, rob_idx stays 3.
REQ-036 Seven issues to rd=7 (BUSY_CNT_W=3) -> ready=0 on eighth attempt; same cycle commit rd=7 -> ready=1, counter remains 7, rob_idx updated.
REQ-037 Commit rd=9 with counter 0 -> comm_err_o=1 for one cycle, counter stays 0.
REQ-038 Issue rd=0 rob=4 with SKIP_X0=1 -> ready=1, rs1=0 reads busy=0, rob_idx=0.
REQ-039 Counters on regs 2,3 non-zero, flush_i with simultaneous issue rd=2 -> next cycle all busy=0, rob_idx=0.
REQ-040 rst_i asserted between clock edges with regs busy -> outputs 0 before next edge; release -> ready=1.
